demux_1_2_stream: RTL and testbench
===================================

DEMUX_1_2_STREAM -- requirements
Module: demux_1_2_stream

Interface
REQ-001 Parameter N, default 64, data width in bits; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  N  payload to route.
REQ-005 in_sel  input  1  destination select: 0 routes to port 0, 1 routes to port 1.
REQ-006 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 in_ready  output  1  block accepts the current input this cycle.
REQ-008 out0_data  output  N  port 0 payload.
REQ-009 out0_valid  output  1  port 0 holds a word.
REQ-010 out0_ready  input  1  port 0 consumer takes the word this cycle.
REQ-011 out1_data, out1_valid, out1_ready: same widths, directions and meanings as REQ-008..010, for port 1.
REQ-012 cnt0  output  16  count of completed port 0 transfers.
REQ-013 cnt1  output  16  count of completed port 1 transfers.

Function
REQ-014 Each output port has one single-entry holding register (data plus valid flag); outK_data/outK_valid are driven directly from that register.
REQ-015 Transfer on a port: valid and ready both high at a rising edge; input accept: in_valid and in_ready both high at a rising edge.
REQ-016 in_ready is combinational: high when rst is low and the register selected by in_sel is empty or is being drained this cycle (outK_valid and outK_ready both high for K = in_sel).
REQ-017 in_ready does not depend on the state of the unselected port.
REQ-018 On input accept, the register selected by in_sel loads in_data and sets its valid flag; the other register is unchanged.
REQ-019 Latency: a word accepted at edge t is presented on outK_data with outK_valid high from edge t onward (visible in the cycle after acceptance); no combinational path from in_data to any outK_data.
REQ-020 Throughput: one word per cycle per port when the consumer holds ready high; a simultaneous drain and reload of the same register keeps valid high with the new data.
REQ-021 Port K valid clears after a transfer unless a reload of port K occurs at the same edge.
REQ-022 While outK_valid is high and outK_ready is low, outK_data and outK_valid hold stable.
REQ-023 outK_ready asserted with outK_valid low has no effect.
REQ-024 in_sel and in_data are ignored when in_valid is low.
REQ-025 Both ports may transfer at the same edge independently; one port stalling never blocks the other port, except for inputs selecting the stalled port.
REQ-026 Ordering: words routed to the same port leave in acceptance order; there is no ordering guarantee between ports.
REQ-027 cntK increments by 1 on each port K transfer and wraps from 16'hFFFF to 16'h0000; it does not saturate.
REQ-028 No word is ever dropped or duplicated.

Reset
REQ-029 While rst is high at a rising edge: out0_valid = out1_valid = 0, out0_data = out1_data = 0, cnt0 = cnt1 = 0.
REQ-030 While rst is high, in_ready = 0 and no input is accepted; a word held in a register when rst asserts is discarded and not counted.
REQ-031 In the first cycle after rst deasserts, in_ready = 1 for either in_sel value.

Verification
REQ-032 Reset, then in_valid = 1, in_sel = 0, in_data = 64'hDEAD_BEEF_0000_0001, out0_ready = 1 -> next cycle out0_valid = 1, out0_data matches; one cycle later cnt0 = 1; out1_valid stays 0.
REQ-033 Port 1 stall: out1_ready = 0, two words to port 1 (A, then B) -> A is accepted, in_ready = 0 for B, out1_data holds A; raise out1_ready -> A transfers, B is accepted at the same edge, and B is presented next cycle.
REQ-034 Independence: port 0 full and stalled, in_sel = 1 stream of 4 words with out1_ready = 1 -> all 4 are accepted back-to-back, cnt1 = 4, and port 0 is unchanged.
REQ-035 Full throughput: alternate in_sel 0/1 for 100 cycles with both readies high -> in_ready is always 1, cnt0 = cnt1 = 50, and per-port order is preserved.
REQ-036 Counter wrap: drive 65537 port 0 transfers -> cnt0 = 1.
REQ-037 Reset mid-operation: both registers valid, assert rst for 1 cycle -> both valids 0, counters 0, and the held words never appear on the outputs.

Source files
------------

// File: rtl/demux_1_2_stream.sv
// Purpose: 1-to-2 stream demultiplexer. Each accepted input word is routed by
//          in_sel into a single-entry holding register for output port 0 or 1.
//          Per-port 16-bit transfer counters wrap on overflow.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_data/in_sel/in_valid  input stream (payload, destination select, valid)
//   in_ready                 combinational accept indication for the input
//   outK_data/outK_valid     port K registered payload and valid (K = 0, 1)
//   outK_ready               port K consumer ready
//   cnt0, cnt1               completed transfer counts per port
module demux_1_2_stream #(
  parameter int unsigned N = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out0_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [N-1:0]  out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [15:0]   cnt0,
  output logic [15:0]   cnt1
);

  localparam int unsigned CNT_W = 16;

  logic [N-1:0]     out0_data_q, out0_data_d;
  logic [N-1:0]     out1_data_q, out1_data_d;
  logic             out0_valid_q, out0_valid_d;
  logic             out1_valid_q, out1_valid_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic xfer0, xfer1, accept;

  // Port transfers complete when a held word meets a ready consumer.
  assign xfer0 = out0_valid_q & out0_ready;
  assign xfer1 = out1_valid_q & out1_ready;

  // Ready looks only at the selected port: empty, or draining this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (in_sel) in_ready = !out1_valid_q || xfer1;
      else        in_ready = !out0_valid_q || xfer0;
    end
  end

  assign accept = in_valid & in_ready;

  // Next-state for holding registers and counters.
  always_comb begin
    out0_data_d  = out0_data_q;
    out1_data_d  = out1_data_q;
    out0_valid_d = out0_valid_q;
    out1_valid_d = out1_valid_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (xfer0) begin
      out0_valid_d = 1'b0;
      cnt0_d       = cnt0_q + CNT_W'(1);
    end
    if (xfer1) begin
      out1_valid_d = 1'b0;
      cnt1_d       = cnt1_q + CNT_W'(1);
    end

    // A reload at the same edge as a drain keeps valid high with new data.
    if (accept) begin
      if (in_sel) begin
        out1_data_d  = in_data;
        out1_valid_d = 1'b1;
      end else begin
        out0_data_d  = in_data;
        out0_valid_d = 1'b1;
      end
    end
  end

  // State registers; reset discards held words without counting them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;
  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux_1_2_stream.sv
// Purpose: directed self-checking bench for demux_1_2_stream (N = 64).
module tb_demux_1_2_stream;

  localparam int unsigned N = 64;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [N-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [15:0]   cnt0;
  logic [15:0]   cnt1;

  int vectors;
  int miscompares;

  demux_1_2_stream #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h1111;
    out0_ready = 1'b0; out1_ready = 1'b0;
    step();
    step();
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    vectors++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b%b exp=00", out0_valid, out1_valid); end
    vectors++;
    if (out0_data !== '0 || out1_data !== '0) begin miscompares++; $display("FAIL reset_data got=%h/%h exp=0/0", out0_data, out1_data); end
    vectors++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready_sel0 got=%b exp=1", in_ready); end
    in_sel = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready_sel1 got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hDEAD_BEEF_0000_0001; out0_ready = 1'b1;
    step();
    in_valid = 1'b0; in_sel = 1'b1; in_data = 64'h5555;
    vectors++;
    if (out0_valid !== 1'b1 || out0_data !== 64'hDEAD_BEEF_0000_0001) begin miscompares++; $display("FAIL basic_present got=%b/%h exp=1/deadbeef00000001", out0_valid, out0_data); end
    vectors++;
    if (out1_valid !== 1'b0 || cnt0 !== 16'd0) begin miscompares++; $display("FAIL basic_pre got v1=%b cnt0=%0d exp 0/0", out1_valid, cnt0); end
    step();
    vectors++;
    if (cnt0 !== 16'd1 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin miscompares++; $display("FAIL basic_done got cnt0=%0d v0=%b v1=%b exp 1/0/0", cnt0, out0_valid, out1_valid); end
    step();
    vectors++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd0) begin miscompares++; $display("FAIL basic_idle_ready got cnt0=%0d cnt1=%0d exp 1/0", cnt0, cnt1); end
  endtask

  task automatic test_stall();
    do_reset();
    out1_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b1; in_data = 64'hAAAA_0000_0000_000A;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_accept_a got=%b exp=1", in_ready); end
    step();
    in_data = 64'hBBBB_0000_0000_000B;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_block_b got=%b exp=0", in_ready); end
    step();
    vectors++;
    if (out1_valid !== 1'b1 || out1_data !== 64'hAAAA_0000_0000_000A) begin miscompares++; $display("FAIL stall_hold got=%b/%h exp=1/aaaa00000000000a", out1_valid, out1_data); end
    out1_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out1_valid !== 1'b1 || out1_data !== 64'hBBBB_0000_0000_000B || cnt1 !== 16'd1) begin miscompares++; $display("FAIL stall_b_present got=%b/%h cnt1=%0d exp=1/bbbb00000000000b/1", out1_valid, out1_data, cnt1); end
    step();
    vectors++;
    if (out1_valid !== 1'b0 || cnt1 !== 16'd2 || out0_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got v1=%b cnt1=%0d v0=%b exp 0/2/0", out1_valid, cnt1, out0_valid); end
  endtask

  task automatic test_independence();
    logic [N-1:0] w;
    do_reset();
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hC0C0_0000_0000_00C0;
    step();
    in_sel = 1'b0; in_data = 64'h1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL indep_port0_full got=%b exp=0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      w = 64'h1000 + 64'(i);
      in_sel = 1'b1; in_data = w;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL indep_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
      vectors++;
      if (out1_valid !== 1'b1 || out1_data !== w) begin miscompares++; $display("FAIL indep_p1[%0d] got=%b/%h exp=1/%h", i, out1_valid, out1_data, w); end
      vectors++;
      if (out0_valid !== 1'b1 || out0_data !== 64'hC0C0_0000_0000_00C0) begin miscompares++; $display("FAIL indep_p0[%0d] got=%b/%h exp=1/c0c00000000000c0", i, out0_valid, out0_data); end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (cnt1 !== 16'd4 || cnt0 !== 16'd0 || out0_valid !== 1'b1) begin miscompares++; $display("FAIL indep_counts got cnt1=%0d cnt0=%0d v0=%b exp 4/0/1", cnt1, cnt0, out0_valid); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] w;
    logic         s;
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s = 1'(i % 2);
      w = {32'hF00D_0000 | 32'(s), 32'(i)};
      in_sel = s; in_data = w;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
      vectors++;
      if (s == 1'b0) begin
        if (out0_valid !== 1'b1 || out0_data !== w || out1_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_p0[%0d] got=%b/%h v1=%b exp=1/%h v1=0", i, out0_valid, out0_data, out1_valid, w); end
      end else begin
        if (out1_valid !== 1'b1 || out1_data !== w || out0_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_p1[%0d] got=%b/%h v0=%b exp=1/%h v0=0", i, out1_valid, out1_data, out0_valid, w); end
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (cnt0 !== 16'd50 || cnt1 !== 16'd50) begin miscompares++; $display("FAIL b2b_counts got=%0d/%0d exp=50/50", cnt0, cnt1); end
  endtask

  task automatic test_wrap();
    do_reset();
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h77;
    repeat (65537) @(posedge clk);
    #1;
    in_valid = 1'b0;
    step();
    vectors++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd0) begin miscompares++; $display("FAIL wrap_cnt got=%0d/%0d exp=1/0", cnt0, cnt1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
    in_sel = 1'b0; in_data = 64'hAB00_0000_0000_0000;
    step();
    in_sel = 1'b1; in_data = 64'hCD00_0000_0000_0000;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin miscompares++; $display("FAIL mid_loaded got=%b%b exp=11", out0_valid, out1_valid); end
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hEE;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
    step();
    rst = 1'b0; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    vectors++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin miscompares++; $display("FAIL mid_cleared got v=%b%b cnt=%0d/%0d exp 00 0/0", out0_valid, out1_valid, cnt0, cnt1); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== '0 || out1_data !== '0 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
        miscompares++;
        $display("FAIL mid_gone[%0d] got v=%b%b d=%h/%h cnt=%0d/%0d exp 00 0/0 0/0", i, out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_independence();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
